apb4_timer_regs: RTL and testbench

//  Register bank behind the APB4 slave interface: consumes addr/read_en/write_en/byte_strobe/wdata, returns rdata.

---
 rtl/apb_timer_pkg.sv | 53 +++++
 rtl/apb_timer_core.sv | 54 +++++
 rtl/apb4_timer_regs.sv | 107 ++++++++++
 tb/tb_apb4_timer_regs.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB4 timer register bank: word offsets,
// CTRL field positions, and small helpers for byte-lane merging and
// CTRL readback.
package apb_timer_pkg;

    // Word offsets (byte address >> 2)
    localparam int unsigned WORD_CTRL    = 0;
    localparam int unsigned WORD_LOAD    = 1;
    localparam int unsigned WORD_VALUE   = 2;
    localparam int unsigned WORD_INTSTAT = 3;
    localparam int unsigned WORD_ID      = 4;

    // CTRL bit indices and PRESCALE field bounds
    localparam int unsigned CTRL_ENABLE  = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_ONESHOT = 2;
    localparam int unsigned PRESCALE_LSB = 8;
    localparam int unsigned PRESCALE_MSB = 15;

    // INTSTAT bit index
    localparam int unsigned FIRED_BIT    = 0;

    typedef struct packed {
        logic [7:0] prescale;
        logic       oneshot;
        logic       irq_en;
        logic       enable;
    } ctrl_t;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strobe);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strobe[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return merged;
    endfunction

    // Place the stored CTRL fields at their bus positions; other bits read 0.
    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w                            = '0;
        w[CTRL_ENABLE]               = c.enable;
        w[CTRL_IRQ_EN]               = c.irq_en;
        w[CTRL_ONESHOT]              = c.oneshot;
        w[PRESCALE_MSB:PRESCALE_LSB] = c.prescale;
        return w;
    endfunction

endpackage

// File: rtl/apb_timer_core.sv
// Down-counter core of the APB4 timer: holds VALUE, the optional prescaler
// and produces the one-cycle fire pulse when a tick lands on VALUE==0.
// Configuration macro: APB_TIMER_PRESCALER_EN (defined = tick every
// PRESCALE+1 cycles; undefined = tick every cycle while enabled).
module apb_timer_core (
    input  logic        pclk,
    input  logic        preset,
    input  logic        enable,
    input  logic        oneshot,
    input  logic [7:0]  prescale,
    input  logic        ctrl_wr,
    input  logic        load_wr,
    input  logic [31:0] load_val,
    output logic [31:0] value,
    output logic        fire,
    output logic        oneshot_done
);

    logic tick;

`ifdef APB_TIMER_PRESCALER_EN
    logic [7:0] pcnt;

    // Prescale counter: restarts whenever the timer is stopped or CTRL is written.
    always_ff @(posedge pclk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (preset || !enable || ctrl_wr) pcnt <= '0;
        else if (pcnt == prescale)        pcnt <= '0;
        else                              pcnt <= pcnt + 8'd1;
    end

    assign tick = enable && (pcnt == prescale);
`else
    logic unused_cfg;
    assign unused_cfg = ^{prescale, ctrl_wr};
    assign tick       = enable;
`endif

    assign fire         = tick && (value == '0);
    assign oneshot_done = fire && oneshot;

    // VALUE: a LOAD write wins; otherwise decrement, reload or park at 0 on a tick.
    always_ff @(posedge pclk) begin
        if (preset) begin
            value <= '0;
        end else if (load_wr) begin
            value <= load_val;
        end else if (tick) begin
            if (value != '0)  value <= value - 32'd1;
            else if (!oneshot) value <= load_val;
        end
    end

endmodule

// File: rtl/apb4_timer_regs.sv
// APB4 timer register bank: address decode, CTRL/LOAD/INTSTAT storage and
// the registered read mux around apb_timer_core. Zero-wait-state access.
// Configuration macro: APB_TIMER_PRESCALER_EN (enables CTRL.PRESCALE storage).
module apb4_timer_regs
    import apb_timer_pkg::*;
#(
    parameter int          ADDRWIDTH = 12,
    parameter logic [31:0] ID_VALUE  = 32'hA0B4_0001
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic                 read_en,
    input  logic                 write_en,
    input  logic [3:0]           byte_strobe,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 irq
);

    localparam int WW = ADDRWIDTH - 2;

    logic [WW-1:0] word;
    logic          unused_addr;
    logic          ctrl_wr, load_wr, intstat_wr;
    ctrl_t         ctrl_q;
    logic [31:0]   load_q, load_next, value;
    logic          fired_q, fire, oneshot_done;
    logic [31:0]   rd_mux;

    assign word        = addr[ADDRWIDTH-1:2];
    assign unused_addr = ^addr[1:0];

    assign ctrl_wr    = write_en && (word == WW'(WORD_CTRL));
    assign load_wr    = write_en && (word == WW'(WORD_LOAD));
    assign intstat_wr = write_en && (word == WW'(WORD_INTSTAT));

    assign load_next = load_wr ? byte_merge(load_q, wdata, byte_strobe) : load_q;

    apb_timer_core u_core (
        .pclk         (pclk),
        .preset       (preset),
        .enable       (ctrl_q.enable),
        .oneshot      (ctrl_q.oneshot),
        .prescale     (ctrl_q.prescale),
        .ctrl_wr      (ctrl_wr),
        .load_wr      (load_wr),
        .load_val     (load_next),
        .value        (value),
        .fire         (fire),
        .oneshot_done (oneshot_done)
    );

    // CTRL: software write of lane 0 beats the one-shot hardware ENABLE clear.
    always_ff @(posedge pclk) begin
        if (preset) begin
            ctrl_q <= '0;
        end else begin
            if (ctrl_wr && byte_strobe[0]) begin
                ctrl_q.enable  <= wdata[CTRL_ENABLE];
                ctrl_q.irq_en  <= wdata[CTRL_IRQ_EN];
                ctrl_q.oneshot <= wdata[CTRL_ONESHOT];
            end else if (oneshot_done) begin
                ctrl_q.enable  <= 1'b0;
            end
`ifdef APB_TIMER_PRESCALER_EN
            if (ctrl_wr && byte_strobe[1]) ctrl_q.prescale <= wdata[PRESCALE_MSB:PRESCALE_LSB];
`endif
        end
    end

    // LOAD: byte-lane write.
    always_ff @(posedge pclk) begin
        if (preset) load_q <= '0;
        else        load_q <= load_next;
    end

    // INTSTAT.FIRED: hardware set beats software W1C.
    always_ff @(posedge pclk) begin
        if (preset)                                                fired_q <= 1'b0;
        else if (fire)                                             fired_q <= 1'b1;
        else if (intstat_wr && byte_strobe[0] && wdata[FIRED_BIT]) fired_q <= 1'b0;
    end

    assign irq = fired_q & ctrl_q.irq_en;

    // Read mux over pre-edge register values.
    always_comb begin
        // NOTE: default assignment first so no path leaves rd_mux unassigned (no latch).
        rd_mux = '0;
        case (word)
            WW'(WORD_CTRL):    rd_mux = ctrl_word(ctrl_q);
            WW'(WORD_LOAD):    rd_mux = load_q;
            WW'(WORD_VALUE):   rd_mux = value;
            WW'(WORD_INTSTAT): rd_mux = {31'd0, fired_q};
            WW'(WORD_ID):      rd_mux = ID_VALUE;
            default:           rd_mux = '0;
        endcase
    end

    // Registered read data: sampled on every read_en edge, held otherwise.
    always_ff @(posedge pclk) begin
        if (preset)       rdata <= '0;
        else if (read_en) rdata <= rd_mux;
    end

endmodule

// File: tb/tb_apb4_timer_regs.sv
// Self-checking bench for apb4_timer_regs: directed vector table, hand
// sequences for timer corner cases, and a randomized run against a
// behavioural model of the register map.
module tb_apb4_timer_regs;

    localparam logic [31:0] ID_EXP = 32'hA0B4_0001;
`ifdef APB_TIMER_PRESCALER_EN
    localparam logic [31:0] CTRL_ALL = 32'h0000_FF07;
`else
    localparam logic [31:0] CTRL_ALL = 32'h0000_0007;
`endif

    logic        pclk = 1'b0;
    logic        preset, read_en, write_en;
    logic [11:0] addr;
    logic [3:0]  byte_strobe;
    logic [31:0] wdata, rdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    apb4_timer_regs #(.ADDRWIDTH(12), .ID_VALUE(ID_EXP)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .addr        (addr),
        .read_en     (read_en),
        .write_en    (write_en),
        .byte_strobe (byte_strobe),
        .wdata       (wdata),
        .rdata       (rdata),
        .irq         (irq)
    );

    // ---------------- behavioural model ----------------
    bit        m_en, m_ie, m_os, m_fired;
    bit [7:0]  m_ps, m_pcnt;
    bit [31:0] m_load, m_val, m_rdata;

    function automatic bit [31:0] lane_mask(input bit [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic bit [31:0] model_read(input bit [9:0] w);
        case (w)
            10'd0:   return {16'd0, m_ps, 5'd0, m_os, m_ie, m_en};
            10'd1:   return m_load;
            10'd2:   return m_val;
            10'd3:   return {31'd0, m_fired};
            10'd4:   return ID_EXP;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, advance the model, then settle past the edge.
    task automatic cyc(input bit rst, input bit re, input bit we, input logic [11:0] a,
                       input logic [3:0] s, input logic [31:0] d);
        bit        tick, fire, c_wr, l_wr, i_wr;
        bit [9:0]  w;
        bit [31:0] rd, nload, nval;
        preset = rst; read_en = re; write_en = we;
        addr = a; byte_strobe = s; wdata = d;
        w  = a[11:2];
        rd = model_read(w);
`ifdef APB_TIMER_PRESCALER_EN
        tick = m_en && (m_pcnt == m_ps);
`else
        tick = m_en;
`endif
        if (rst) begin
            {m_en, m_ie, m_os, m_fired} = '0;
            m_ps = 0; m_pcnt = 0; m_load = 0; m_val = 0; m_rdata = 0;
        end else begin
            fire  = tick && (m_val == 0);
            c_wr  = we && (w == 0);
            l_wr  = we && (w == 1);
            i_wr  = we && (w == 3);
            nload = l_wr ? ((m_load & ~lane_mask(s)) | (d & lane_mask(s))) : m_load;
            if (l_wr)                   nval = nload;
            else if (tick && m_val != 0) nval = m_val - 1;
            else if (tick && !m_os)      nval = m_load;
            else                         nval = m_val;
            m_pcnt  = (!m_en || c_wr || m_pcnt == m_ps) ? 8'd0 : m_pcnt + 8'd1;
            m_fired = fire ? 1'b1 : ((i_wr && s[0] && d[0]) ? 1'b0 : m_fired);
            if (c_wr && s[0]) {m_os, m_ie, m_en} = d[2:0];
            else if (fire && m_os) m_en = 1'b0;
`ifdef APB_TIMER_PRESCALER_EN
            if (c_wr && s[1]) m_ps = d[15:8];
`endif
            m_load = nload;
            m_val  = nval;
            if (re) m_rdata = rd;
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic idle();                 cyc(0, 0, 0, 12'h0, 4'h0, 32'h0); endtask
    task automatic rd(input logic [11:0] a); cyc(0, 1, 0, a, 4'h0, 32'h0);    endtask
    task automatic wr(input logic [11:0] a, input logic [3:0] s, input logic [31:0] d);
        cyc(0, 0, 1, a, s, d);
    endtask
    task automatic do_reset(); cyc(1, 0, 0, 12'h0, 4'h0, 32'h0); endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        bit          rst, re, we;
        logic [11:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(input string n, input bit rst, input bit re, input bit we,
                                input logic [11:0] a, input logic [3:0] s,
                                input logic [31:0] d, input logic [31:0] exp);
        vec_t v;
        v.name = n; v.rst = rst; v.re = re; v.we = we;
        v.a = a; v.s = s; v.d = d; v.exp = exp;
        return v;
    endfunction

    vec_t vecs [17];

    initial begin
        logic [31:0] per_exp [5];
        per_exp = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};

        vecs[0]  = mk("reset_rdata",     1, 0, 0, 12'h000, 4'h0, 32'h0,         32'h0);
        vecs[1]  = mk("idle_rdata",      0, 0, 0, 12'h000, 4'h0, 32'h0,         32'h0);
        vecs[2]  = mk("id_setup",        0, 1, 0, 12'h010, 4'h0, 32'h0,         ID_EXP);
        vecs[3]  = mk("id_access",       0, 1, 0, 12'h010, 4'h0, 32'h0,         ID_EXP);
        vecs[4]  = mk("hole_setup",      0, 1, 0, 12'h0FC, 4'h0, 32'h0,         32'h0);
        vecs[5]  = mk("hole_access",     0, 1, 0, 12'h0FC, 4'h0, 32'h0,         32'h0);
        vecs[6]  = mk("load_part_wr",    0, 0, 1, 12'h004, 4'h3, 32'hFFFF_FFFF, 32'h0);
        vecs[7]  = mk("load_rd_setup",   0, 1, 0, 12'h004, 4'h0, 32'h0,         32'h0000_FFFF);
        vecs[8]  = mk("load_rd_access",  0, 1, 0, 12'h004, 4'h0, 32'h0,         32'h0000_FFFF);
        vecs[9]  = mk("value_after_ld",  0, 1, 0, 12'h008, 4'h0, 32'h0,         32'h0000_FFFF);
        vecs[10] = mk("ctrl_wr_hold",    0, 0, 1, 12'h000, 4'hF, 32'hFFFF_FFFF, 32'h0000_FFFF);
        vecs[11] = mk("ctrl_rd_setup",   0, 1, 0, 12'h000, 4'h0, 32'h0,         CTRL_ALL);
        vecs[12] = mk("ctrl_rd_access",  0, 1, 0, 12'h003, 4'h0, 32'h0,         CTRL_ALL);
        vecs[13] = mk("ctrl_clear",      0, 0, 1, 12'h000, 4'hF, 32'h0,         CTRL_ALL);
        vecs[14] = mk("intstat_rd",      0, 1, 0, 12'h00C, 4'h0, 32'h0,         32'h0);
        vecs[15] = mk("hole_wr",         0, 0, 1, 12'h0FC, 4'hF, 32'hFFFF_FFFF, 32'h0);
        vecs[16] = mk("ctrl_after_hole", 0, 1, 0, 12'h000, 4'h0, 32'h0,         32'h0);

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].rst, vecs[i].re, vecs[i].we, vecs[i].a, vecs[i].s, vecs[i].d);
            check(vecs[i].name, rdata, vecs[i].exp);
            if (i == 0) check("reset_irq", {31'd0, irq}, 32'd0);
        end

        // Periodic countdown with reload and interrupt.
        do_reset();
        wr(12'h004, 4'hF, 32'd3);
        wr(12'h000, 4'hF, 32'h3);
        for (int k = 0; k < 5; k++) begin
            rd(12'h008);
            check($sformatf("periodic_value_%0d", k), rdata, per_exp[k]);
            if (k == 2) check("periodic_irq_before", {31'd0, irq}, 32'd0);
            if (k == 3) check("periodic_irq_fired", {31'd0, irq}, 32'd1);
        end
        rd(12'h00C);
        check("periodic_fired", rdata, 32'd1);
        wr(12'h000, 4'hF, 32'h0);

        // One-shot: stops with VALUE parked at 0.
        do_reset();
        wr(12'h004, 4'hF, 32'd2);
        wr(12'h000, 4'hF, 32'h5);
        repeat (3) idle();
        for (int k = 0; k < 10; k++) begin
            rd(12'h008);
            check($sformatf("oneshot_value_%0d", k), rdata, 32'd0);
        end
        rd(12'h000);
        check("oneshot_ctrl", rdata, 32'h4);
        rd(12'h00C);
        check("oneshot_fired", rdata, 32'd1);
        check("oneshot_irq_masked", {31'd0, irq}, 32'd0);

        // W1C colliding with the hardware set, then a clean W1C.
        do_reset();
        wr(12'h004, 4'hF, 32'd2);
        wr(12'h000, 4'hF, 32'h3);
        idle();
        idle();
        wr(12'h00C, 4'h1, 32'h1);
        check("w1c_vs_fire_irq", {31'd0, irq}, 32'd1);
        wr(12'h00C, 4'h1, 32'h1);
        check("w1c_clear_irq", {31'd0, irq}, 32'd0);
        wr(12'h000, 4'hF, 32'h0);
        rd(12'h00C);
        check("w1c_clear_fired", rdata, 32'd0);

`ifdef APB_TIMER_PRESCALER_EN
        // Prescaler: VALUE moves every PRESCALE+1 cycles.
        do_reset();
        wr(12'h004, 4'hF, 32'd1);
        wr(12'h000, 4'hF, 32'h0000_0301);
        for (int k = 1; k <= 12; k++) begin
            rd(12'h008);
            check($sformatf("prescale_value_%0d", k), rdata,
                  (k <= 4 || k >= 9) ? 32'd1 : 32'd0);
        end
`endif

        // Reset in the middle of counting.
        do_reset();
        wr(12'h004, 4'hF, 32'd5);
        wr(12'h000, 4'hF, 32'h3);
        idle();
        idle();
        do_reset();
        check("midreset_rdata", rdata, 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            rd(12'(k * 4));
            check($sformatf("midreset_reg_%0d", k), rdata, 32'd0);
        end
        repeat (8) idle();
        check("midreset_no_irq", {31'd0, irq}, 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit          r_rst, r_re, r_we;
            logic [11:0] r_a;
            logic [31:0] r_d;
            int          pick;
            r_rst = ($urandom_range(0, 499) == 0);
            r_re  = $urandom_range(0, 1) == 1;
            r_we  = ($urandom_range(0, 2) == 0);
            pick  = $urandom_range(0, 6);
            if (pick <= 4)      r_a = 12'(pick * 4 + $urandom_range(0, 3));
            else if (pick == 5) r_a = 12'h014;
            else                r_a = 12'($urandom);
            r_d = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0107);
            cyc(r_rst, r_re, r_we, r_a, 4'($urandom), r_d);
            check("rand_rdata", rdata, m_rdata);
            check("rand_irq", {31'd0, irq}, {31'd0, m_fired & m_ie});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
